// File: rtl/fifo_rd_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_streamer_pkg
// Description : Shared constants, types and helpers for the FIFO read-side
//               streamer and its skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_streamer_pkg;

    // Depth of the skid buffer and the width needed to count 0..SKID_DEPTH
    localparam int SKID_DEPTH = 2;
    localparam int LEVEL_W    = 2;

    // Supported FIFO read-data latencies
    localparam int RD_LAT_COMB = 0;   // combinational read of current address
    localparam int RD_LAT_REG  = 1;   // registered read, data one clock later

    typedef logic [LEVEL_W-1:0] level_t;

    // True when the read latency is one the streamer knows how to absorb
    function automatic bit rd_latency_legal(input int lat);
        return (lat == RD_LAT_COMB) || (lat == RD_LAT_REG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_streamer_skid.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf2
// Description : Two-entry ordered register buffer. Head entry is presented on
//               o_data; simultaneous push and pop are both honoured.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf2
    import fifo_rd_streamer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output level_t           o_level,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    level_t           level_q, level_d;
    logic             w_pop;

    // A pop against an empty buffer has nothing to remove
    assign w_pop = i_pop & (level_q != 2'd0);

    // Next-state: flush empties, otherwise shift/fill according to push/pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (i_flush) begin
            level_d = 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (level_q == 2'd0) begin
                        head_d  = i_data;
                        level_d = 2'd1;
                    end else if (level_q == 2'd1) begin
                        tail_d  = i_data;
                        level_d = 2'd2;
                    end
                end
                2'b01: begin
                    if (level_q == 2'd2) begin
                        head_d  = tail_q;
                        level_d = 2'd1;
                    end else begin
                        level_d = 2'd0;
                    end
                end
                2'b11: begin
                    // Level unchanged; at level 2 the tail moves up to head
                    if (level_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = i_data;
                    end else begin
                        head_d = i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    assign o_level = level_q;
    assign o_data  = head_q;
    assign o_valid = (level_q != 2'd0);

    // The credit logic upstream must never push into a full buffer
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && !w_pop && !i_flush && (level_q == 2'd2)));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_streamer
// Description : Read-domain client of the dual-clock sample FIFO. Issues pops
//               against skid-buffer credit, absorbs the FIFO read latency and
//               streams samples out as valid/ready at one sample per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_streamer
    import fifo_rd_streamer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rd_empty,
    output logic             o_rd_inc,
    input  logic [WIDTH-1:0] i_rd_data,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_level,
    output logic [CNT_W-1:0] o_sample_cnt
);

    // Reject unsupported read latencies at elaboration
    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_rd_latency
        $error("fifo_rd_streamer: RD_LATENCY must be 0 or 1");
    end

    level_t           w_level;
    logic             w_valid;
    logic             w_deq;
    logic             w_push;
    logic [2:0]       w_occ;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A sample leaves when the FIR takes it; a flush cycle delivers nothing
    assign w_deq = w_valid & i_ready & ~i_flush;

    // Occupancy counts both buffered samples and pops still in flight
    assign w_occ = {1'b0, w_level} + {2'b00, inflight_q};

    // Pop only if the sample is guaranteed a slot, counting this cycle's deq
    assign o_rd_inc = ~i_rst & ~i_flush & ~i_rd_empty &
                      (w_occ < (3'd2 + {2'b00, w_deq}));

    if (RD_LATENCY == RD_LAT_COMB) begin : g_lat_comb
        // Read data is present in the pop cycle itself
        assign w_push     = o_rd_inc;
        assign inflight_d = 1'b0;
    end else begin : g_lat_reg
        // Read data arrives the clock after the pop
        assign w_push     = inflight_q;
        assign inflight_d = o_rd_inc;
    end

    // In-flight pop tracker
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Delivered-sample counter, wraps naturally
    always_comb begin
        cnt_d = cnt_q + CNT_W'(w_deq);
    end

    // Counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_deq),
        .i_flush (i_flush),
        .i_data  (i_rd_data),
        .o_level (w_level),
        .o_data  (o_data),
        .o_valid (w_valid)
    );

    assign o_valid      = w_valid;
    assign o_level      = w_level;
    assign o_sample_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_streamer
// Description : Directed bench for fifo_rd_streamer. Instance A uses the
//               registered-read FIFO model, instance B the combinational one
//               with a 4-bit sample counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_streamer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // ---------------- instance A: RD_LATENCY=1, CNT_W=16 ----------------
    logic        a_empty, a_inc, a_flush, a_valid, a_ready;
    logic [7:0]  a_rdata = 8'h00;
    logic [7:0]  a_data;
    logic [1:0]  a_level;
    logic [15:0] a_cnt;
    logic [7:0]  a_mem [0:2047];
    int          a_rd = 0;
    int          a_wr = 0;
    int          a_pops = 0;
    logic        a_hold = 1'b0;

    assign a_empty = (a_rd == a_wr) | a_hold;

    // Registered-read FIFO model
    always @(posedge clk) begin
        if (a_inc) begin
            a_rdata <= a_mem[a_rd % 2048];
            a_rd    <= a_rd + 1;
            a_pops  <= a_pops + 1;
        end
    end

    fifo_rd_streamer #(.WIDTH(8), .RD_LATENCY(1), .CNT_W(16)) u_dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rd_empty   (a_empty),
        .o_rd_inc     (a_inc),
        .i_rd_data    (a_rdata),
        .i_flush      (a_flush),
        .o_valid      (a_valid),
        .i_ready      (a_ready),
        .o_data       (a_data),
        .o_level      (a_level),
        .o_sample_cnt (a_cnt)
    );

    // ---------------- instance B: RD_LATENCY=0, CNT_W=4 ----------------
    logic        b_empty, b_inc, b_valid, b_ready;
    logic [7:0]  b_rdata;
    logic [7:0]  b_data;
    logic [1:0]  b_level;
    logic [3:0]  b_cnt;
    logic [7:0]  b_mem [0:2047];
    int          b_rd = 0;
    int          b_wr = 0;

    assign b_empty = (b_rd == b_wr);
    assign b_rdata = b_mem[b_rd % 2048];

    // Combinational-read FIFO model
    always @(posedge clk) begin
        if (b_inc) b_rd <= b_rd + 1;
    end

    fifo_rd_streamer #(.WIDTH(8), .RD_LATENCY(0), .CNT_W(4)) u_dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rd_empty   (b_empty),
        .o_rd_inc     (b_inc),
        .i_rd_data    (b_rdata),
        .i_flush      (1'b0),
        .o_valid      (b_valid),
        .i_ready      (b_ready),
        .o_data       (b_data),
        .o_level      (b_level),
        .o_sample_cnt (b_cnt)
    );

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the start of the next cycle and leave margin after the edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_pops;
        int exp_idx;
        int ndel;
        int cyc;

        a_flush = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            a_mem[i] = 8'h00;
            b_mem[i] = 8'h00;
        end

        // ---- reset with a non-empty FIFO: nothing may be popped ----
        for (int i = 0; i < 16; i++) a_mem[i] = 8'(i + 1);
        a_wr = 16;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("rst_inc",   a_inc,   0);
            check_eq("rst_valid", a_valid, 0);
            check_eq("rst_level", a_level, 0);
            check_eq("rst_cnt",   a_cnt,   0);
            check_eq("rst_data",  a_data,  0);
        end

        // ---- streaming, RD_LATENCY=1 ----
        next_cycle();
        rst     = 1'b0;
        a_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            check_eq("stream_inc",   a_inc,   (k < 16) ? 1 : 0);
            check_eq("stream_valid", a_valid, (k >= 2) ? 1 : 0);
            if (k >= 2) check_eq("stream_data", a_data, k - 1);
            next_cycle();
        end
        @(negedge clk);
        check_eq("stream_cnt",   a_cnt,   16);
        check_eq("stream_drain", a_valid, 0);

        // ---- back-pressure ----
        next_cycle();
        a_ready = 1'b0;
        for (int i = 0; i < 16; i++) a_mem[(a_wr + i) % 2048] = 8'(i + 1);
        a_wr      = a_wr + 16;
        base_pops = a_pops;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_inc", a_inc, (k < 2) ? 1 : 0);
            if (k >= 2) check_eq("bp_hold_data", a_data, 8'h01);
            if (k == 4) begin
                check_eq("bp_level", a_level, 2);
                check_eq("bp_pops",  a_pops - base_pops, 2);
            end
            next_cycle();
        end
        a_ready = 1'b1;
        for (int k = 5; k <= 20; k++) begin
            @(negedge clk);
            check_eq("bp_rel_valid", a_valid, 1);
            check_eq("bp_rel_data",  a_data,  k - 4);
            next_cycle();
        end
        @(negedge clk);
        check_eq("bp_drain", a_valid, 0);
        check_eq("bp_cnt",   a_cnt,   32);

        // ---- random stall and random empty ----
        next_cycle();
        exp_idx = a_wr;
        for (int i = 0; i < 1000; i++) a_mem[(a_wr + i) % 2048] = 8'((i * 7 + 3) & 255);
        a_wr = a_wr + 1000;
        ndel = 0;
        cyc  = 0;
        while (ndel < 1000 && cyc < 20000) begin
            a_ready = 1'($urandom_range(0, 1));
            a_hold  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("rand_level_max", (a_level <= 2'd2) ? 1 : 0, 1);
            if (a_valid && a_ready) begin
                check_eq("rand_data", a_data, a_mem[exp_idx % 2048]);
                exp_idx++;
                ndel++;
            end
            next_cycle();
            cyc++;
        end
        check_eq("rand_delivered", ndel, 1000);
        a_hold  = 1'b0;
        a_ready = 1'b1;
        @(negedge clk);
        check_eq("rand_cnt",   a_cnt,   1032);
        check_eq("rand_level", a_level, 0);

        // ---- flush with a sample in flight ----
        next_cycle();
        for (int i = 0; i < 4; i++) a_mem[(a_wr + i) % 2048] = 8'(8'hA1 + i);
        a_wr = a_wr + 4;
        @(negedge clk);
        check_eq("fl_pop0", a_inc, 1);
        next_cycle();
        @(negedge clk);
        check_eq("fl_pop1",   a_inc,   1);
        check_eq("fl_valid1", a_valid, 0);
        next_cycle();
        a_flush = 1'b1;
        @(negedge clk);
        check_eq("fl_level_before", a_level, 1);
        check_eq("fl_head_before",  a_data,  8'hA1);
        check_eq("fl_no_pop",       a_inc,   0);
        next_cycle();
        a_flush = 1'b0;
        @(negedge clk);
        check_eq("fl_valid_after", a_valid, 0);
        check_eq("fl_level_after", a_level, 0);
        next_cycle();
        @(negedge clk);
        check_eq("fl_inflight_gone", a_valid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("fl_next_valid", a_valid, 1);
        check_eq("fl_next_data",  a_data,  8'hA3);
        next_cycle();
        @(negedge clk);
        check_eq("fl_last_data", a_data, 8'hA4);
        next_cycle();
        @(negedge clk);
        check_eq("fl_drain", a_valid, 0);
        check_eq("fl_cnt",   a_cnt,   1034);

        // ---- RD_LATENCY=0 with a 4-bit counter wrap ----
        next_cycle();
        for (int i = 0; i < 17; i++) b_mem[(b_wr + i) % 2048] = 8'(8'h30 + i);
        b_wr    = b_wr + 17;
        b_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            check_eq("l0_inc",   b_inc,   (k < 17) ? 1 : 0);
            check_eq("l0_valid", b_valid, (k >= 1) ? 1 : 0);
            if (k >= 1) check_eq("l0_data", b_data, 8'h30 + k - 1);
            if (k == 16) check_eq("l0_cnt15", b_cnt, 15);
            if (k == 17) check_eq("l0_cnt_wrap", b_cnt, 0);
            next_cycle();
        end
        @(negedge clk);
        check_eq("l0_cnt_end", b_cnt,   1);
        check_eq("l0_drain",   b_valid, 0);
        check_eq("l0_level",   b_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_streamer.md
Name: fifo_rd_streamer

Overview:
- Read-side client of the dual-clock sample FIFO, clocked entirely in the read domain.
- Drives the FIFO pop strobe from the FIFO empty flag.
- Absorbs the FIFO memory read latency in a 2-entry skid buffer.
- Presents samples to the multiplexed FIR datapath as a valid/ready stream at full throughput (one sample per clock).

Parameters:
- WIDTH, 8: sample width; matches the FIFO data width.
- RD_LATENCY, 1: FIFO read-data latency in clocks after the pop cycle. Legal values are 0 (combinational read of the current address) and 1 (registered read).
- CNT_W, 16: width of the delivered-sample counter.

Ports:
- i_clk  in  1  read-domain clock
- i_rst  in  1  reset, synchronous, active-high
- i_rd_empty  in  1  FIFO empty flag (already synchronised to i_clk)
- o_rd_inc  out  1  FIFO pop strobe; one pop per clock it is high
- i_rd_data  in  WIDTH  FIFO read data
- i_flush  in  1  synchronous discard of buffered and in-flight samples
- o_valid  out  1  o_data holds a sample
- i_ready  in  1  FIR accepts a sample this clock
- o_data  out  WIDTH  head sample
- o_level  out  2  samples held in the skid buffer (0..2)
- o_sample_cnt  out  CNT_W  samples delivered since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset: when i_rst is high at a clock edge, all state clears.
  - o_valid=0, o_level=0, o_sample_cnt=0, o_data=0.
  - In-flight tracker cleared.
  - o_rd_inc is forced 0 combinationally while i_rst=1.
- Definitions:
  - deq = o_valid & i_ready.
  - inflight = number of pops issued whose data has not yet been captured. Always 0 when RD_LATENCY=0; 0 or 1 when RD_LATENCY=1.
- Pop rule (combinational):
  - o_rd_inc = !i_rst & !i_flush & !i_rd_empty & (o_level + inflight - deq < 2).
  - o_rd_inc depends combinationally on i_ready. This is required for full throughput.
- Capture:
  - RD_LATENCY=0: i_rd_data is written into the buffer at the edge ending the cycle in which o_rd_inc=1.
  - RD_LATENCY=1: i_rd_data is written at the edge ending the cycle after o_rd_inc=1.
- Skid buffer: ordered 2-entry register FIFO.
  - o_data = oldest entry; o_valid = (o_level != 0).
  - A capture and a deq in the same clock are both honoured; level stays unchanged. At level 2 this shifts the entries correctly.
  - Overflow is impossible by construction; an assertion checks that no capture occurs at level 2 without deq.
- Ordering: samples leave in exact FIFO pop order. No drops and no duplicates, except on flush.
- Steady state with i_ready=1 and FIFO non-empty: one pop and one deq per clock. First o_valid appears RD_LATENCY+1 clocks after i_rd_empty falls.
- Empty: when i_rd_empty=1, no pop is issued. o_valid drains to 0 as the FIR consumes the buffered samples.
- Back-pressure: when i_ready=0 and level=2, o_rd_inc=0 and o_data is held stable. o_data must not change while o_valid=1 and i_ready=0.
- Flush:
  - At the edge where i_flush=1: level→0 and o_valid→0.
  - Any in-flight sample (RD_LATENCY=1) is discarded when it arrives on the following clock.
  - No pop occurs during the flush cycle.
  - o_sample_cnt is not cleared, and deq is suppressed in the flush cycle.
- Counter: o_sample_cnt increments by 1 on every deq; it wraps to 0 after 2^CNT_W-1.
- Reset mid-stream: buffered and in-flight samples are lost. The FIFO itself is reset by its own domain reset, which is not this block's concern.

Decomposition:
- Shared package/include holds:
  - SKID_DEPTH=2
  - the level width (2)
  - legal RD_LATENCY values, plus an elaboration check that rejects other values.
- One sub-module: skid_buf2, a 2-entry ordered register buffer.
  - Inputs: push, pop, flush, data.
  - Outputs: level, head data, valid.
  - Uses the same i_clk / i_rst convention.
- The pop-credit logic, in-flight tracker and counter stay in the top module.

Test Plan:
- Reset: hold i_rst=1 for 3 clocks with i_rd_empty=0. Required: o_rd_inc=0, o_valid=0, o_level=0, o_sample_cnt=0 throughout.
- Streaming, RD_LATENCY=1: FIFO model preloaded with 0x01..0x10, i_ready=1. Required:
  - o_rd_inc high for 16 consecutive clocks.
  - o_data = 0x01..0x10 on consecutive clocks, first valid 2 clocks after the first pop.
  - o_sample_cnt=16 at the end.
- Back-pressure: same preload with i_ready=0 for 5 clocks. Required:
  - o_level reaches 2 and exactly 2 pops have occurred.
  - o_data=0x01 stable.
  - After releasing i_ready, order is preserved with no gaps.
- Random stall: i_ready random at 50%, i_rd_empty random, 1000 samples. Required: scoreboard matches pop order exactly; o_level never exceeds 2.
- Flush with in-flight data: i_flush asserted the clock after a pop, level=1, RD_LATENCY=1. Required:
  - o_valid=0 the next clock.
  - The in-flight sample never appears on o_data.
  - The next delivered sample is the following FIFO entry.
- Counter wrap and RD_LATENCY=0: CNT_W=4, 17 deliveries. Required: o_sample_cnt=1 at the end; data is valid 1 clock after its pop.
